// File: rtl/afifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : afifo_pkg
//  Description : Shared definitions for the asynchronous FIFO pointer
//                handlers: default address width, derived depth and the
//                Gray-to-binary conversion used by both clock domains.
//  Revision    : 1.0 - initial release
// ============================================================================
package afifo_pkg;

    localparam int c_WIDTH = 4;
    localparam int c_DEPTH = 1 << c_WIDTH;

    // Gray to binary on a zero-extended 32-bit value; callers cast the
    // result back down to their own pointer width.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage : afifo_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop clock-domain-crossing synchronizer for a Gray
//                coded pointer, asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-domain pointer and status controller of the async
//                FIFO. Advances binary/Gray write pointers on accepted
//                writes and derives full, almost-full, occupancy and a
//                sticky overflow flag against the synchronized read pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl
    import afifo_pkg::*;
#(
    parameter int width        = c_WIDTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_en,
    input  logic             ovf_clr,
    input  logic [width:0]   rptr,
    output logic [width:0]   wptr,
    output logic [width-1:0] w_addr,
    output logic             w_ok,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic [width:0]   wr_count
);

    localparam logic [width:0] c_AFULL = (width+1)'(AFULL_THRESH);

    logic [width:0] r_bin;
    logic [width:0] r_wptr;
    logic           r_full;
    logic           r_afull;
    logic           r_overflow;
    logic [width:0] r_wr_count;

    logic [width:0] w_rptr_sync;
    logic [width:0] w_rbin;
    logic [width:0] w_bin_next;
    logic [width:0] w_gray_next;
    logic [width:0] w_full_cmp;
    logic [width:0] w_count_next;
    logic           w_ok_int;

    sync_2ff #(
        .WIDTH (width + 1)
    ) u_rptr_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rptr),
        .o_q   (w_rptr_sync)
    );

    // A write is only accepted while there is known free space.
    assign w_ok_int     = w_en && !r_full;
    assign w_bin_next   = r_bin + (width+1)'(w_ok_int);
    assign w_gray_next  = (w_bin_next >> 1) ^ w_bin_next;
    assign w_rbin       = (width+1)'(gray2bin(32'(w_rptr_sync)));
    // Full when the writer is exactly one lap ahead: the top two Gray bits
    // differ and the rest match.
    assign w_full_cmp   = {~w_rptr_sync[width:width-1], w_rptr_sync[width-2:0]};
    // Stale read pointer can only make this larger than the true occupancy.
    assign w_count_next = w_bin_next - w_rbin;

    // Pointer and status flags follow the post-write pointer with no extra lag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin      <= '0;
            r_wptr     <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_bin      <= w_bin_next;
            r_wptr     <= w_gray_next;
            r_full     <= (w_gray_next == w_full_cmp);
            r_afull    <= (w_count_next >= c_AFULL);
            r_wr_count <= w_count_next;
        end
    end

    // Sticky overflow; the clear wins over a same-cycle rejected write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end else if (w_en && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign wptr        = r_wptr;
    assign w_addr      = r_bin[width-1:0];
    assign w_ok        = w_ok_int;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign overflow    = r_overflow;
    assign wr_count    = r_wr_count;

endmodule : wptr_full_ctrl
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Scoreboard bench for wptr_full_ctrl (width=4, thresh=12).
//                Stimulus pushes model predictions; a monitor pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full_ctrl;

    logic       clk;
    logic       reset;
    logic       w_en;
    logic       ovf_clr;
    logic [4:0] rptr;
    logic [4:0] wptr;
    logic [3:0] w_addr;
    logic       w_ok;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [4:0] wr_count;

    wptr_full_ctrl #(
        .width        (4),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .rptr        (rptr),
        .wptr        (wptr),
        .w_addr      (w_addr),
        .w_ok        (w_ok),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w_ok;
        int w_addr;
        int wptr;
        int full;
        int afull;
        int ovf;
        int cnt;
        int true_occ;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: counts of writes and reads as plain integers.
    int   m_wr;
    int   rd_now;
    int   m_full;
    int   m_ovf;
    int   rd_hist[$];

    function automatic int gray5(input int x);
        int b;
        b = x & 31;
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One write-domain cycle: drive, predict, enqueue.
    task automatic cycle(input bit we, input bit clr, input int rd);
        exp_t e;
        int   stale;
        int   c;
        @(negedge clk);
        w_en    = we;
        ovf_clr = clr;
        rptr    = 5'(gray5(rd));
        rd_now  = rd;
        c = rd_hist.size();
        rd_hist.push_back(rd);
        // Flags on this edge see the read pointer from two cycles back.
        stale = (c >= 2) ? rd_hist[c-2] : 0;
        e.w_ok   = (we && m_full == 0) ? 1 : 0;
        e.w_addr = m_wr % 16;
        if (e.w_ok == 1) m_wr++;
        e.cnt      = m_wr - stale;
        e.full     = (e.cnt == 16) ? 1 : 0;
        e.afull    = (e.cnt >= 12) ? 1 : 0;
        e.wptr     = gray5(m_wr);
        e.ovf      = clr ? 0 : ((we && m_full == 1) ? 1 : m_ovf);
        e.true_occ = m_wr - rd;
        m_full = e.full;
        m_ovf  = e.ovf;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        w_en    = 1'b0;
        ovf_clr = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("rst_wptr",     int'(wptr),        0);
        check("rst_waddr",    int'(w_addr),      0);
        check("rst_wok",      int'(w_ok),        0);
        check("rst_full",     int'(full),        0);
        check("rst_afull",    int'(almost_full), 0);
        check("rst_overflow", int'(overflow),    0);
        check("rst_wr_count", int'(wr_count),    0);
        rptr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        m_wr   = 0;
        rd_now = 0;
        m_full = 0;
        m_ovf  = 0;
        rd_hist.delete();
        #1;
        check("post_rst_waddr", int'(w_addr), 0);
    endtask

    // Monitor: combinational strobe before the edge, registers after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("w_ok",   int'(w_ok),   e.w_ok);
                check("w_addr", int'(w_addr), e.w_addr);
                @(posedge clk);
                #1;
                check("wptr",        int'(wptr),        e.wptr);
                check("full",        int'(full),        e.full);
                check("almost_full", int'(almost_full), e.afull);
                check("overflow",    int'(overflow),    e.ovf);
                check("wr_count",    int'(wr_count),    e.cnt);
                n_checks++;
                if (int'(wr_count) < e.true_occ) begin
                    n_fail++;
                    $display("FAIL wr_count_lower_bound: got %0d required >= %0d", wr_count, e.true_occ);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int adv;
        reset   = 1'b1;
        w_en    = 1'b0;
        ovf_clr = 1'b0;
        rptr    = '0;
        m_wr = 0; rd_now = 0; m_full = 0; m_ovf = 0;
        do_reset();

        // Reset in the middle of a write stream.
        repeat (5) cycle(1, 0, 0);
        do_reset();

        // Fill to full with the reader parked at 0.
        repeat (16) cycle(1, 0, 0);
        settle();
        check("fill_full",  int'(full),     1);
        check("fill_count", int'(wr_count), 16);
        check("fill_wptr",  int'(wptr),     5'b11000);

        // Writes while full are dropped and flagged.
        repeat (2) cycle(1, 0, 0);
        settle();
        check("ovf_set",     int'(overflow), 1);
        check("ovf_wptr",    int'(wptr),     5'b11000);
        cycle(0, 1, 0);
        settle();
        check("ovf_cleared", int'(overflow), 0);

        // Clear and rejected write in the same cycle.
        cycle(1, 1, 0);
        settle();
        check("simul_ovf",  int'(overflow), 0);
        check("simul_wptr", int'(wptr),     5'b11000);

        // Reader frees four entries; visible on the third edge.
        repeat (3) cycle(0, 0, 4);
        settle();
        check("free_full",  int'(full),     0);
        check("free_count", int'(wr_count), 12);
        cycle(1, 0, 4);
        settle();
        check("free_write_count", int'(wr_count), 13);

        // Reader tracking the writer across the pointer wrap.
        repeat (40) cycle(1, 0, m_wr);
        settle();
        check("wrap_full", int'(full), 0);

        // Randomized traffic with a monotonic reader that never passes the writer.
        for (int i = 0; i < 300; i++) begin
            adv = m_wr - rd_now;
            if (adv > 2) adv = 2;
            cycle(($urandom % 4) != 0, ($urandom % 8) == 0,
                  rd_now + int'($urandom_range(0, adv)));
        end
        repeat (3) cycle(0, 0, rd_now);
        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wptr_full_ctrl
`default_nettype wire

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and status controller for the asynchronous FIFO. It is the write-domain counterpart of the read-pointer handler. It takes the read domain's Gray read pointer through an internal 2-flop synchronizer and advances the binary and Gray write pointers on accepted writes. It produces the RAM write address, registered full / almost-full flags, a sticky overflow flag and a write-side occupancy count. The Gray write pointer `wptr` goes to the read-domain synchronizer, which feeds the read handler's empty compare.

## Interface
- `width`, 4: address width; FIFO depth = 2^width; legal range ≥ 2.
- `AFULL_THRESH`, 12: occupancy at or above which `almost_full` asserts; legal range 1..2^width.
- `clk`  input  1  write-domain clock.
- `reset`  input  1  asynchronous, active-low reset.
- `w_en`  input  1  write request.
- `ovf_clr`  input  1  synchronous clear of `overflow`.
- `rptr`  input  width+1  Gray read pointer, launched from the read domain.
- `wptr`  output  width+1  registered Gray write pointer.
- `w_addr`  output  width  RAM write address, equal to `bin[width-1:0]`.
- `w_ok`  output  1  combinational write strobe to the RAM, equal to `w_en && !full`.
- `full`  output  1  registered FIFO full.
- `almost_full`  output  1  registered; set when occupancy ≥ `AFULL_THRESH`.
- `overflow`  output  1  sticky; a write was attempted while full.
- `wr_count`  output  width+1  registered occupancy as seen from the write domain.

## Operation
- **Synchronizer:** `rptr` passes through two flops, `rq1` then `rq2`. `rptr_sync` = `rq2`.
- **Binary pointer:** `bin_next = bin + w_ok`. The add is modulo 2^(width+1), and the extra MSB is the wrap bit.
- **Gray pointer:** `gray_next = (bin_next >> 1) ^ bin_next`. `wptr` is registered from `gray_next`.
- **Full:** `full <= (gray_next == {~rptr_sync[width:width-1], rptr_sync[width-2:0]})`.
- **Occupancy:** `rbin = gray2bin(rptr_sync)`. Then `wr_count <= bin_next - rbin`, modulo 2^(width+1), which gives a range of 0..2^width.
- **Almost full:** `almost_full <= ((bin_next - rbin) >= AFULL_THRESH)`.
- **Overflow:**
  - `ovf_clr` has priority and clears `overflow` to 0.
  - Otherwise, `w_en && full` sets `overflow` to 1.
  - If both occur in the same cycle, `overflow` ends at 0. The dropped write is not recorded.
- **Write while full:** the pointer does not move and the RAM is not written.
- **Flags are pessimistic:** `full`, `almost_full` and `wr_count` use a read pointer that is 2 cycles stale. They may over-report occupancy but must never under-report it.
- **Wrap-around:** after 2^width writes, `bin[width]` toggles. After 2^(width+1) writes, `bin` returns to 0, and comparisons stay correct across the wrap.
- **Reset:** while `reset` = 0, all flops are 0: `bin`, `wptr`, `rq1`, `rq2`, `full`, `almost_full`, `overflow` and `wr_count`. Asserting reset mid-operation clears them immediately and asynchronously. Deassertion is assumed already synchronized to `clk` at the top level.

## Timing
- `w_ok` is combinational, in the same cycle as `w_en`. `w_addr` is valid in that same cycle, and the RAM captures on that `clk` edge.
- `wptr`, `w_addr`, `full`, `almost_full` and `wr_count` update on the edge that accepts the write, so they are valid the next cycle.
- `full` asserts in the cycle immediately after the write that fills the last entry. There is no extra latency.
- Read-side frees become visible 2 `clk` edges after `rptr` changes. `full`, `almost_full` and `wr_count` then reflect them on the following edge, i.e. edge 3.
- `overflow` is set on the edge after the rejected `w_en`.

## Structure
- **Shared package `afifo_pkg`:**
  - default `width`;
  - function `gray2bin`, so the read side can reuse it;
  - localparam `DEPTH = 1 << width`.
- **Sub-module `sync_2ff`** (parameterised width): the `rq1`/`rq2` pair with async active-low reset. It is reused for the read-side copy of `wptr`.
- **Top:** pointer registers, flag registers and overflow logic.

## Test plan
All scenarios use `width=4` and `AFULL_THRESH=12`, with `rptr` held at 0 unless stated.

- **Reset:** assert `reset`=0 mid-stream after 5 writes. Required: all outputs 0 immediately; `w_addr`=0 after release.
- **Fill to full:** 16 back-to-back `w_en`.
  - After the 12th write: `almost_full`=1 and `wr_count`=12.
  - After the 16th write: `full`=1, `wr_count`=16, `wptr`=5'b11000.
- **Overflow:** with `full`=1, pulse `w_en` for 2 cycles.
  - Required: `w_ok`=0, `wptr` unchanged, `overflow`=1 and held.
  - Then `ovf_clr` → `overflow`=0 next cycle.
- **Read frees space:** from full, set `rptr` to Gray(4) = 5'b00110.
  - Edge 3: `full`=0 and `wr_count`=12.
  - One further write → `full`=0 and `wr_count`=13.
- **Wrap-around:** the reader tracks the writer (`rptr` = `wptr` delayed).
  - Perform 40 writes in total.
  - Required: `bin` wraps through 31→0; `full` is never asserted; `w_addr` sequence is 0..15 repeating.
- **Simultaneous events:** `w_en` while full in the same cycle as `ovf_clr`. Required: `overflow` stays 0 and no write is accepted.
